// File: rtl/calc_key_entry_if.sv
// rtl/calc_key_entry_if.sv - key event input and operand/operator outputs of calc_key_entry
interface calc_key_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] o_num1;
  logic [3:0] o_num2;
  logic [3:0] o_op;
  logic [1:0] o_stage;
  logic       o_show;
  logic       o_reject;

  // Key source side: drives key events, observes the sequencer outputs
  modport master (
    output key_valid, key_code,
    input  o_num1, o_num2, o_op, o_stage, o_show, o_reject
  );

  // Sequencer side
  modport slave (
    input  key_valid, key_code,
    output o_num1, o_num2, o_op, o_stage, o_show, o_reject
  );
endinterface

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - key-entry sequencer building num1/op/num2 for the calculator
module calc_key_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input logic             clk,
  input logic             rst,
  calc_key_entry_if.slave kif
);

  typedef enum logic [1:0] {
    S_NUM1 = 2'd0,
    S_NUM2 = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] K_CLEAR  = 4'hA;
  localparam logic [3:0] K_EQUALS = 4'hB;

  state_t      state_q, state_d;
  logic [3:0]  num1_q, num1_d;
  logic [3:0]  num2_q, num2_d;
  logic [3:0]  op_q, op_d;
  logic        show_q, show_d;
  logic        reject_q, reject_d;
  logic        num1_set_q, num1_set_d;
  logic        num2_set_q, num2_set_d;
  logic [31:0] cnt_q, cnt_d;

  logic is_digit;
  logic is_op;
  logic armed;
  logic to_fire;

  assign is_digit = (kif.key_code <= 4'd9);
  assign is_op    = (kif.key_code >= 4'hC);
  // A partial entry exists only once num1 is set or an operator was taken
  assign armed    = (state_q == S_NUM2) || num1_set_q;
  // A key in the same cycle wins over the timeout
  assign to_fire  = TO_EN && !kif.key_valid && armed && (cnt_q == TO_LAST);

  // Next-state: key decoding per state, timeout auto-clear and idle counter
  always_comb begin
    state_d    = state_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    op_d       = op_q;
    show_d     = show_q;
    reject_d   = 1'b0;
    num1_set_d = num1_set_q;
    num2_set_d = num2_set_q;
    cnt_d      = cnt_q;

    if (kif.key_valid || (state_q == S_SHOW) || to_fire) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (kif.key_valid) begin
      if (kif.key_code == K_CLEAR) begin
        state_d    = S_NUM1;
        num1_d     = '0;
        num2_d     = '0;
        op_d       = '0;
        show_d     = 1'b0;
        num1_set_d = 1'b0;
        num2_set_d = 1'b0;
      end else begin
        case (state_q)
          S_NUM1: begin
            if (is_digit) begin
              num1_d     = kif.key_code;
              num1_set_d = 1'b1;
            end else if (is_op && num1_set_q) begin
              op_d    = kif.key_code;
              state_d = S_NUM2;
            end else begin
              reject_d = 1'b1;
            end
          end
          S_NUM2: begin
            if (is_digit) begin
              num2_d     = kif.key_code;
              num2_set_d = 1'b1;
            end else if (is_op) begin
              op_d = kif.key_code;
            end else if ((kif.key_code == K_EQUALS) && num2_set_q) begin
              state_d = S_SHOW;
              show_d  = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
          S_SHOW: begin
            // Only a digit leaves SHOW; chaining on a wide result is not possible
            if (is_digit) begin
              num1_d     = kif.key_code;
              num2_d     = '0;
              op_d       = '0;
              num1_set_d = 1'b1;
              num2_set_d = 1'b0;
              show_d     = 1'b0;
              state_d    = S_NUM1;
            end else begin
              reject_d = 1'b1;
            end
          end
          default: begin
            state_d = S_NUM1;
          end
        endcase
      end
    end else if (to_fire) begin
      state_d    = S_NUM1;
      num1_d     = '0;
      num2_d     = '0;
      op_d       = '0;
      show_d     = 1'b0;
      num1_set_d = 1'b0;
      num2_set_d = 1'b0;
    end
  end

  // State and output registers; rst overrides any key in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_NUM1;
      num1_q     <= '0;
      num2_q     <= '0;
      op_q       <= '0;
      show_q     <= 1'b0;
      reject_q   <= 1'b0;
      num1_set_q <= 1'b0;
      num2_set_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      op_q       <= op_d;
      show_q     <= show_d;
      reject_q   <= reject_d;
      num1_set_q <= num1_set_d;
      num2_set_q <= num2_set_d;
      cnt_q      <= cnt_d;
    end
  end

  assign kif.o_num1   = num1_q;
  assign kif.o_num2   = num2_q;
  assign kif.o_op     = op_q;
  assign kif.o_stage  = state_q;
  assign kif.o_show   = show_q;
  assign kif.o_reject = reject_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// tb/tb_calc_key_entry.sv - scoreboard bench for calc_key_entry with directed key sequences
module tb_calc_key_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_key_entry_if kif ();

  calc_key_entry #(.TIMEOUT_CYCLES(20)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  n1;
    logic [3:0]  n2;
    logic [3:0]  op;
    logic [1:0]  st;
    logic        sh;
    logic        rj;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic        end_req = 1'b0;
  logic        end_done = 1'b0;

  logic [3:0] l_n1 = '0, l_n2 = '0, l_op = '0;
  logic [1:0] l_st = '0;
  logic       l_sh = 1'b0;

  // Cycle index of the most recent rising edge
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare outputs against every expectation due at this cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc_cnt) begin
        errors = errors + 1;
        $display("FAIL stale_expect cyc=%0d got_cyc=%0d", e.cyc, cyc_cnt);
      end else if ({kif.o_num1, kif.o_num2, kif.o_op, kif.o_stage, kif.o_show, kif.o_reject}
                   !== {e.n1, e.n2, e.op, e.st, e.sh, e.rj}) begin
        errors = errors + 1;
        $display("FAIL outputs cyc=%0d got n1=%h n2=%h op=%h st=%0d sh=%b rj=%b exp n1=%h n2=%h op=%h st=%0d sh=%b rj=%b",
                 cyc_cnt, kif.o_num1, kif.o_num2, kif.o_op, kif.o_stage, kif.o_show, kif.o_reject,
                 e.n1, e.n2, e.op, e.st, e.sh, e.rj);
      end
    end
    if (end_req && !end_done) begin
      checks = checks + 1;
      if (sb.size() != 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
      end
      end_done <= 1'b1;
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge that samples them
  task automatic drive(input logic r, input logic kv, input logic [3:0] kc,
                       input logic [3:0] n1, input logic [3:0] n2, input logic [3:0] op,
                       input logic [1:0] st, input logic sh, input logic rj);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    kif.key_valid = kv;
    kif.key_code  = kc;
    e.cyc = cyc_cnt + 1;
    e.n1 = n1; e.n2 = n2; e.op = op; e.st = st; e.sh = sh; e.rj = rj;
    sb.push_back(e);
    l_n1 = n1; l_n2 = n2; l_op = op; l_st = st; l_sh = sh;
  endtask

  task automatic key(input logic [3:0] kc, input logic [3:0] n1, input logic [3:0] n2,
                     input logic [3:0] op, input logic [1:0] st, input logic sh, input logic rj);
    drive(1'b0, 1'b1, kc, n1, n2, op, st, sh, rj);
  endtask

  // Idle cycles with outputs expected to hold at their last values
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, l_n1, l_n2, l_op, l_st, l_sh, 1'b0);
  endtask

  task automatic zeros_idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1);
  end

  initial begin
    kif.key_valid = 1'b0;
    kif.key_code  = 4'h0;

    // Reset state
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    zeros_idle(2);

    // Basic entry 7 + 3 =
    key(4'h7, 4'h7, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h7, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    key(4'h3, 4'h7, 4'h3, 4'hF, 2'd1, 1'b0, 1'b0);
    key(4'hB, 4'h7, 4'h3, 4'hF, 2'd2, 1'b1, 1'b0);
    idle(3);
    // Clear in SHOW
    key(4'hA, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

    // Operator / equals without an operand are rejected
    key(4'hE, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    key(4'hB, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    idle(1);
    key(4'h2, 4'h2, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'h9, 4'h9, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hD, 4'h9, 4'h0, 4'hD, 2'd1, 1'b0, 1'b0);
    key(4'h4, 4'h9, 4'h4, 4'hD, 2'd1, 1'b0, 1'b0);
    key(4'h8, 4'h9, 4'h8, 4'hD, 2'd1, 1'b0, 1'b0);
    key(4'hB, 4'h9, 4'h8, 4'hD, 2'd2, 1'b1, 1'b0);

    // Operator replacement in NUM2, rejects in SHOW, new entry from SHOW
    key(4'hA, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'h5, 4'h5, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h5, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    key(4'hB, 4'h5, 4'h0, 4'hF, 2'd1, 1'b0, 1'b1);
    key(4'hE, 4'h5, 4'h0, 4'hE, 2'd1, 1'b0, 1'b0);
    key(4'h6, 4'h5, 4'h6, 4'hE, 2'd1, 1'b0, 1'b0);
    key(4'hB, 4'h5, 4'h6, 4'hE, 2'd2, 1'b1, 1'b0);
    key(4'hF, 4'h5, 4'h6, 4'hE, 2'd2, 1'b1, 1'b1);
    key(4'hB, 4'h5, 4'h6, 4'hE, 2'd2, 1'b1, 1'b1);
    key(4'h4, 4'h4, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

    // Timeout with num1 set in NUM1: clears exactly 20 cycles after the key
    idle(19);
    zeros_idle(1);
    // Unarmed counter never fires
    zeros_idle(30);

    // Timeout in NUM2
    key(4'h3, 4'h3, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h3, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    idle(19);
    zeros_idle(2);

    // A key 19 cycles after the last one restarts the idle count
    key(4'h3, 4'h3, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h3, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    idle(18);
    key(4'h2, 4'h3, 4'h2, 4'hF, 2'd1, 1'b0, 1'b0);
    idle(19);
    zeros_idle(1);

    // A key on the very cycle the timeout would fire wins
    key(4'h3, 4'h3, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h3, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    idle(19);
    key(4'h5, 4'h3, 4'h5, 4'hF, 2'd1, 1'b0, 1'b0);
    key(4'hB, 4'h3, 4'h5, 4'hF, 2'd2, 1'b1, 1'b0);
    // SHOW holds through long idle
    idle(100);

    // rst wins over a key in the same cycle, and flags are cleared
    key(4'h1, 4'h1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h1, 4'h0, 4'hF, 2'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'hF, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b1);
    zeros_idle(1);

    // key_valid held high three cycles: three events, no reject
    key(4'h8, 4'h8, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'h8, 4'h8, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    key(4'h8, 4'h8, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    idle(3);

    @(posedge clk);
    @(posedge clk);
    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
    if (!end_done) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL end_handshake got=0 exp=1");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
